// File: rtl/sr_cmd_pkg.sv
// Shared definitions for the SR command arbiter: op encodings and the
// packed command word held in the arbiter's one-entry command register.
package sr_cmd_pkg;

   // Widest flag index the arbiter supports (NFLAG up to 32).
   localparam int IDX_MAX_W = 5;

   // {s,r} command encoding as seen on req_op.
   typedef enum logic [1:0] {
      OP_HOLD = 2'b00,
      OP_RST  = 2'b01,
      OP_SET  = 2'b10,
      OP_ILL  = 2'b11
   } op_e;

   // One latched command: target flag index and operation.
   typedef struct packed {
      logic [IDX_MAX_W-1:0] idx;
      op_e                  op;
   } cmd_t;

endpackage

// File: rtl/sr_flag_cell.sv
// Single clocked SR flag cell. {s,r} = 10 sets, 01 clears, 00 holds.
// Both high: holds by default; toggles when SR_CMD_ARBITER_TOGGLE_EN is
// defined (JK behaviour).
module sr_flag_cell (
   input  logic clk,
   input  logic rst_n,
   input  logic s,
   input  logic r,
   output logic q,
   output logic q_bar
);

   // Flag state update from the s/r strobes.
   // NOTE: sequential state is written with non-blocking assignments only,
   // so every flop samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= 1'b0;
      end else begin
         case ({s, r})
            2'b10:   q <= 1'b1;
            2'b01:   q <= 1'b0;
`ifdef SR_CMD_ARBITER_TOGGLE_EN
            2'b11:   q <= ~q;
`else
            2'b11:   q <= q;
`endif
            default: q <= q;
         endcase
      end
   end

   assign q_bar = ~q;

endmodule

// File: rtl/sr_cmd_arbiter.sv
// Round-robin arbiter feeding a bank of SR flag cells through a one-entry
// command register. A command accepted on edge N is applied on edge N+1.
// Optional feature: define SR_CMD_ARBITER_TOGGLE_EN to make op 11 a toggle
// instead of an illegal command counted in err_cnt.
module sr_cmd_arbiter
   import sr_cmd_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int NFLAG = 8
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NREQ-1:0]                  req_valid,
   output logic [NREQ-1:0]                  req_ready,
   input  logic [NREQ*$clog2(NFLAG)-1:0]    req_idx,
   input  logic [NREQ*2-1:0]                req_op,
   output logic [NFLAG-1:0]                 flag_q,
   output logic [NFLAG-1:0]                 flag_qb,
   output logic                             err_pulse,
   output logic [7:0]                       err_cnt
);

   localparam int IW = $clog2(NFLAG);
   localparam int PW = $clog2(NREQ);

   logic [PW-1:0]    rr_ptr;
   logic [PW-1:0]    gnt_idx;
   logic             gnt_found;
   int               cand;
   logic             accept;
   logic [IW-1:0]    sel_idx;
   logic [1:0]       sel_op;
   logic             cmd_valid;
   cmd_t             cmd_q;
   logic [NFLAG-1:0] s_vec;
   logic [NFLAG-1:0] r_vec;

   // Round-robin search: first valid requester at or after rr_ptr.
   // NOTE: every variable gets a default at the top of the block so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = 0;
      for (int k = 0; k < NREQ; k++) begin
         cand = int'(rr_ptr) + k;
         if (cand >= NREQ) cand = cand - NREQ;
         if (!gnt_found && req_valid[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = PW'(cand);
         end
      end
   end

   // Grants are suppressed while reset is held so nothing is offered early.
   assign req_ready = (rst_n && gnt_found) ? (NREQ'(1) << gnt_idx) : '0;
   assign accept    = |req_ready;
   assign sel_idx   = req_idx[gnt_idx*IW +: IW];
   assign sel_op    = req_op[gnt_idx*2 +: 2];

   // Pointer advances past the granted requester only when a command is taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (accept) begin
         rr_ptr <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end

   // One-entry command register; refilled every accepting cycle, no stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_valid <= 1'b0;
         cmd_q     <= '0;
      end else begin
         cmd_valid <= accept;
         if (accept) begin
            cmd_q.idx <= IDX_MAX_W'(sel_idx);
            cmd_q.op  <= op_e'(sel_op);
         end
      end
   end

   // Decode the latched command into s/r strobes for the addressed cell only.
   always_comb begin
      s_vec = '0;
      r_vec = '0;
      for (int i = 0; i < NFLAG; i++) begin
         if (cmd_valid && (cmd_q.idx == IDX_MAX_W'(i))) begin
            s_vec[i] = cmd_q.op[1];
            r_vec[i] = cmd_q.op[0];
         end
      end
   end

   for (genvar g = 0; g < NFLAG; g++) begin : g_cell
      sr_flag_cell u_cell (
         .clk   (clk),
         .rst_n (rst_n),
         .s     (s_vec[g]),
         .r     (r_vec[g]),
         .q     (flag_q[g]),
         .q_bar (flag_qb[g])
      );
   end

`ifdef SR_CMD_ARBITER_TOGGLE_EN
   // op 11 is a legal toggle in this build: no error reporting.
   assign err_pulse = 1'b0;
   assign err_cnt   = 8'd0;
`else
   logic       err_pulse_q;
   logic [7:0] err_cnt_q;

   // Flag an illegal op as it is applied; count saturates at 255.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_pulse_q <= 1'b0;
         err_cnt_q   <= 8'd0;
      end else begin
         err_pulse_q <= cmd_valid && (cmd_q.op == OP_ILL);
         if (cmd_valid && (cmd_q.op == OP_ILL) && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
         end
      end
   end

   assign err_pulse = err_pulse_q;
   assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_sr_cmd_arbiter.sv
// Directed bench for sr_cmd_arbiter (NREQ=4, NFLAG=8).
module tb_sr_cmd_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [11:0] req_idx;
   logic [7:0]  req_op;
   logic [7:0]  flag_q;
   logic [7:0]  flag_qb;
   logic        err_pulse;
   logic [7:0]  err_cnt;

   int n_pass  = 0;
   int n_total = 0;

   sr_cmd_arbiter #(.NREQ(4), .NFLAG(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_idx   (req_idx),
      .req_op    (req_op),
      .flag_q    (flag_q),
      .flag_qb   (flag_qb),
      .err_pulse (err_pulse),
      .err_cnt   (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic set_req(input int r, input logic [1:0] op, input logic [2:0] idx);
      req_op[r*2 +: 2]  = op;
      req_idx[r*3 +: 3] = idx;
   endtask

   // Advance one clock and settle just after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [3:0] exp_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
   logic [7:0] exp_flg [5] = '{8'h00, 8'h00, 8'h01, 8'h03, 8'h07};

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_idx   = '0;
      req_op    = '0;
      #2;
      // Reset state, including grants suppressed with requests present.
      check("rst_flag_q", 32'(flag_q), 32'h00);
      check("rst_flag_qb", 32'(flag_qb), 32'hFF);
      check("rst_err_cnt", 32'(err_cnt), 32'd0);
      check("rst_err_pulse", 32'(err_pulse), 32'd0);
      req_valid = 4'b1111;
      #1;
      check("rst_ready", 32'(req_ready), 32'h0);
      req_valid = '0;
      step();
      rst_n = 1'b1;

      // Requester 0: set idx 3 then reset idx 3 back to back.
      req_valid = 4'b0001;
      set_req(0, 2'b10, 3'd3);
      #1;
      check("a_ready0", 32'(req_ready), 32'h1);
      step();
      set_req(0, 2'b01, 3'd3);
      #1;
      check("a_ready1", 32'(req_ready), 32'h1);
      check("a_flag_pre", 32'(flag_q), 32'h00);
      step();
      req_valid = '0;
      check("a_flag_set", 32'(flag_q), 32'h08);
      step();
      check("a_flag_clr", 32'(flag_q), 32'h00);
      check("a_flag_qb", 32'(flag_qb), 32'hFF);

      // Async reset pulse to return rr_ptr to 0, then all four requesting.
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      for (int r = 0; r < 4; r++) set_req(r, 2'b10, 3'(r));
      req_valid = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         #1;
         check($sformatf("b_gnt%0d", k), 32'(req_ready), 32'(exp_gnt[k]));
         check($sformatf("b_flag%0d", k), 32'(flag_q), 32'(exp_flg[k]));
         step();
      end
      req_valid = '0;
      check("b_flag_end", 32'(flag_q), 32'h0F);
      step();
      check("b_flag_end2", 32'(flag_q), 32'h0F);

      // op 11 on idx 5 from requester 2 (rr_ptr is 1, so r2 wins).
      req_valid = 4'b0100;
      set_req(2, 2'b11, 3'd5);
      #1;
      check("c_ready", 32'(req_ready), 32'h4);
      step();
      req_valid = '0;
      check("c_pulse_pre", 32'(err_pulse), 32'd0);
      step();
`ifdef SR_CMD_ARBITER_TOGGLE_EN
      check("c_tog_flag1", 32'(flag_q), 32'h2F);
      check("c_tog_pulse", 32'(err_pulse), 32'd0);
      check("c_tog_cnt", 32'(err_cnt), 32'd0);
      req_valid = 4'b0100;
      step();
      req_valid = '0;
      step();
      check("c_tog_flag2", 32'(flag_q), 32'h0F);
      check("c_tog_pulse2", 32'(err_pulse), 32'd0);
      step();
`else
      check("c_ill_flag", 32'(flag_q), 32'h0F);
      check("c_ill_pulse", 32'(err_pulse), 32'd1);
      check("c_ill_cnt1", 32'(err_cnt), 32'd1);
      step();
      check("c_ill_pulse_end", 32'(err_pulse), 32'd0);
      check("c_ill_cnt_hold", 32'(err_cnt), 32'd1);
      req_valid = 4'b0100;
      repeat (299) step();
      req_valid = '0;
      step();
      check("c_ill_pulse_run", 32'(err_pulse), 32'd1);
      step();
      check("c_ill_sat", 32'(err_cnt), 32'd255);
      check("c_ill_pulse_off", 32'(err_pulse), 32'd0);
      check("c_ill_flag_end", 32'(flag_q), 32'h0F);
`endif

      // Requester 1 sets idx 6; reset pulses before the apply edge.
      req_valid = 4'b0010;
      set_req(1, 2'b10, 3'd6);
      #1;
      check("d_ready", 32'(req_ready), 32'h2);
      step();
      req_valid = '0;
      rst_n = 1'b0;
      #2;
      check("d_flag_rst", 32'(flag_q), 32'h00);
      rst_n = 1'b1;
      step();
      check("d_flag_after", 32'(flag_q), 32'h00);
      check("d_flag_qb", 32'(flag_qb), 32'hFF);
      req_valid = 4'b1111;
      #1;
      check("d_ptr_zero", 32'(req_ready), 32'h1);
      req_valid = '0;
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
